// File: rtl/div16_seq_pkg.sv
// Shared definitions for the sequential 16-bit divider: FSM states, widths and
// the fixed result returned on a zero divisor.
package div16_seq_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int ITERATIONS    = 16;
    localparam int CNT_W         = 5;

    localparam logic [DEFAULT_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/div16_seq_addsub17.sv
// Combinational subtractor a - b computed as a + ~b + 1, shared by the trial
// subtraction and (with a = 0) by the two's-complement negations.
module div16_seq_addsub17 #(
    parameter int W = 17
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] sum;

    assign sum    = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
    assign diff   = sum[W-1:0];
    // Carry out of a + ~b + 1 is set exactly when a >= b.
    assign borrow = ~sum[W];

endmodule

// File: rtl/div16_seq.sv
// Sequential restoring divider: 16 subtract-and-compare iterations on operand
// magnitudes, followed by one sign-fixup cycle that registers the results.
module div16_seq
    import div16_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow,
    output state_t           state_dbg
);

    // Handshake: start is taken only while busy is low; operands and sign are
    // captured on that edge. busy stays high until results are registered, and
    // done pulses for the one cycle in which the new results first appear.

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERATIONS - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;
    logic   load_op, load_div0, do_iter, do_fix;

    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic             q_neg_q, r_neg_q, div0_q, ovf_q;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;
    logic             trial_ok;

    logic [WIDTH:0]   neg_x_in, neg_y_in;
    logic [WIDTH:0]   neg_x_diff, neg_y_diff;
    logic             neg_x_borrow, neg_y_borrow;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             unused_bits;

    // ---------------- datapath arithmetic ----------------
    assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    div16_seq_addsub17 #(.W(WIDTH + 1)) u_trial (
        .a      (r_shift),
        .b      ({1'b0, d_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    assign trial_ok = ~trial_diff[WIDTH];

    // In IDLE the negators produce operand magnitudes; later they negate Q and R.
    assign neg_x_in = (state_q == IDLE) ? {1'b0, dividend} : {1'b0, q_q};
    assign neg_y_in = (state_q == IDLE) ? {1'b0, divisor}  : {1'b0, r_q[WIDTH-1:0]};

    div16_seq_addsub17 #(.W(WIDTH + 1)) u_neg_x (
        .a      ('0),
        .b      (neg_x_in),
        .diff   (neg_x_diff),
        .borrow (neg_x_borrow)
    );

    div16_seq_addsub17 #(.W(WIDTH + 1)) u_neg_y (
        .a      ('0),
        .b      (neg_y_in),
        .diff   (neg_y_diff),
        .borrow (neg_y_borrow)
    );

    assign dvd_mag = (sign & dividend[WIDTH-1]) ? neg_x_diff[WIDTH-1:0] : dividend;
    assign dvs_mag = (sign & divisor[WIDTH-1])  ? neg_y_diff[WIDTH-1:0] : divisor;

    assign unused_bits = ^{trial_borrow, neg_x_borrow, neg_y_borrow,
                           neg_x_diff[WIDTH], neg_y_diff[WIDTH]};

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_op   = 1'b0;
        load_div0 = 1'b0;
        do_iter   = 1'b0;
        do_fix    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        load_div0 = 1'b1;
                        state_d   = FIX;
                    end else begin
                        load_op = 1'b1;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                do_iter = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                do_fix  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            div0_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_op) begin
                q_q     <= dvd_mag;
                d_q     <= dvs_mag;
                r_q     <= '0;
                cnt_q   <= '0;
                q_neg_q <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                r_neg_q <= sign & dividend[WIDTH-1];
                div0_q  <= 1'b0;
                ovf_q   <= sign & (dividend == MIN_NEG) & (divisor == '1);
            end else if (load_div0) begin
                // Q carries the raw dividend through to the remainder output.
                q_q     <= dividend;
                r_q     <= '0;
                cnt_q   <= '0;
                q_neg_q <= 1'b0;
                r_neg_q <= 1'b0;
                div0_q  <= 1'b1;
                ovf_q   <= 1'b0;
            end else if (do_iter) begin
                q_q   <= {q_q[WIDTH-2:0], trial_ok};
                r_q   <= trial_ok ? trial_diff : r_shift;
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (do_fix) begin
                done        <= 1'b1;
                div_by_zero <= div0_q;
                overflow    <= ovf_q;
                if (div0_q) begin
                    quotient  <= DIV0_QUOTIENT;
                    remainder <= q_q;
                end else begin
                    quotient  <= q_neg_q ? neg_x_diff[WIDTH-1:0] : q_q;
                    remainder <= r_neg_q ? neg_y_diff[WIDTH-1:0] : r_q[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_div16_seq.sv
// Bench for div16_seq: directed corner cases plus randomized operands, results
// checked by a queue-based scoreboard against an integer-arithmetic model.
module tb_div16_seq;
    import div16_seq_pkg::*;

    localparam int W  = 16;
    localparam int RW = 2 * W + 2;

    logic         clk, rst, start, sign;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero, overflow;
    logic [W-1:0] quotient, remainder;
    state_t       state_dbg;

    logic [RW-1:0]  exp_q[$];
    logic [2*W:0]   op_q[$];
    int tests = 0;
    int fails = 0;

    div16_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sign        (sign),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero.
    function automatic logic [RW-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi, qi, ri;
        logic [W-1:0] q, r;
        logic ovf;
        if (b == '0) return {16'hFFFF, a, 1'b1, 1'b0};
        if (s) begin
            ai = int'($signed(a));
            bi = int'($signed(b));
        end else begin
            ai = int'(a);
            bi = int'(b);
        end
        qi  = ai / bi;
        ri  = ai % bi;
        q   = qi[W-1:0];
        r   = ri[W-1:0];
        ovf = s && (a == 16'h8000) && (b == 16'hFFFF);
        return {q, r, 1'b0, ovf};
    endfunction

    function automatic int mag(input logic s, input logic [W-1:0] v);
        int x;
        x = s ? int'($signed(v)) : int'(v);
        return (x < 0) ? -x : x;
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge; asserts start for one cycle's worth of setup.
    task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        sign     = s;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        if (push) begin
            exp_q.push_back(model(s, a, b));
            op_q.push_back({s, a, b});
        end
    endtask

    task automatic wait_done(output int lat, output int busy_cycles);
        @(negedge clk);
        start       = 1'b0;
        lat         = 0;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL timeout: got no done after %0d cycles, required done", lat);
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cycles);
        drive(s, a, b, 1'b1);
        wait_done(lat, busy_cycles);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [RW-1:0] mon_exp;
    logic [2*W:0]  mon_op;
    logic [W-1:0]  mon_lhs;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1, required no pending result");
            end else begin
                mon_exp = exp_q.pop_front();
                mon_op  = op_q.pop_front();
                check("result{q,r,dz,ovf}", 64'({quotient, remainder, div_by_zero, overflow}), 64'(mon_exp));
                if (mon_op[W-1:0] != '0) begin
                    mon_lhs = quotient * mon_op[W-1:0] + remainder;
                    check("invariant", 64'(mon_lhs), 64'(mon_op[2*W-1:W]));
                    check("rem_bound",
                          64'(mag(mon_op[2*W], remainder) < mag(mon_op[2*W], mon_op[W-1:0])), 64'(1));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat, bcy, done_seen, mode;
        logic s;
        logic [W-1:0] a, b;

        rst = 1'b1; start = 1'b0; sign = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_quotient", 64'(quotient), 64'(0));
        check("rst_remainder", 64'(remainder), 64'(0));
        check("rst_flags", 64'({div_by_zero, overflow}), 64'(0));
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        issue(1'b0, 16'h0064, 16'h0007, lat, bcy);
        check("u100_7_latency", 64'(lat), 64'(17));
        check("u100_7_busy_cycles", 64'(bcy), 64'(17));
        check("u100_7_q", 64'(quotient), 64'(16'h000E));
        check("u100_7_r", 64'(remainder), 64'(16'h0002));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'(0));
        check("idle_after_done", 64'(busy), 64'(0));

        issue(1'b1, 16'hFF9C, 16'h0007, lat, bcy);
        check("sm100_7_q", 64'(quotient), 64'(16'hFFF2));
        check("sm100_7_r", 64'(remainder), 64'(16'hFFFE));
        issue(1'b1, 16'h0064, 16'hFFF9, lat, bcy);
        check("s100_m7_q", 64'(quotient), 64'(16'hFFF2));
        check("s100_m7_r", 64'(remainder), 64'(16'h0002));
        issue(1'b0, 16'hFFFF, 16'h0001, lat, bcy);
        check("uffff_1_q", 64'(quotient), 64'(16'hFFFF));
        issue(1'b0, 16'h0005, 16'h0009, lat, bcy);
        check("u5_9_r", 64'(remainder), 64'(16'h0005));

        issue(1'b0, 16'h1234, 16'h0000, lat, bcy);
        check("div0_latency", 64'(lat), 64'(1));
        check("div0_q", 64'(quotient), 64'(16'hFFFF));
        check("div0_r", 64'(remainder), 64'(16'h1234));
        check("div0_flag", 64'(div_by_zero), 64'(1));

        issue(1'b1, 16'h8000, 16'hFFFF, lat, bcy);
        check("sovf_q", 64'(quotient), 64'(16'h8000));
        check("sovf_flag", 64'(overflow), 64'(1));
        issue(1'b0, 16'h8000, 16'hFFFF, lat, bcy);
        check("uovf_r", 64'(remainder), 64'(16'h8000));
        check("uovf_flag", 64'(overflow), 64'(0));

        // start re-pulsed mid-operation is ignored
        @(negedge clk);
        drive(1'b0, 16'h0064, 16'h0007, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        drive(1'b1, 16'd1000, 16'd3, 1'b0);
        wait_done(lat, bcy);
        check("repulse_q", 64'(quotient), 64'(16'h000E));
        check("repulse_r", 64'(remainder), 64'(16'h0002));

        // reset mid-operation aborts with no done
        @(negedge clk);
        drive(1'b1, 16'hFF9C, 16'h0007, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", 64'({busy, done, quotient, remainder, div_by_zero, overflow}), 64'(0));
        done_seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'(0));

        // rst and start together: rst wins
        rst = 1'b1;
        drive(1'b0, 16'h0064, 16'h0007, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst_beats_start_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge clk);

        issue(1'b0, 16'h0064, 16'h0007, lat, bcy);
        check("after_abort_q", 64'(quotient), 64'(16'h000E));

        // Randomized, back-to-back (each start lands in the done cycle)
        for (int i = 0; i < 1000; i++) begin
            s    = 1'($urandom_range(0, 1));
            a    = 16'($urandom);
            b    = 16'($urandom);
            mode = $urandom_range(0, 9);
            if (mode == 0) b = '0;
            else if (mode == 1) b = 16'hFFFF;
            else if (mode == 2) a = 16'h8000;
            else if (mode == 3) b = 16'($urandom_range(1, 15));
            issue(s, a, b, lat, bcy);
            check("rand_latency", 64'(lat), 64'((b == '0) ? 1 : 17));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
